// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - integer register file with N read ports, one write port, optional bypass and busy scoreboard
// x0 reads as zero and is never marked busy; the scoreboard bit is set by issue and cleared by writeback.
module reg_file_sb #(
    parameter int RAW    = 5,
    parameter int DW     = 32,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_en,
    input  logic [RAW-1:0]      i_wr_reg,
    input  logic [DW-1:0]       i_wr_data,
    input  logic                i_iss_en,
    input  logic [RAW-1:0]      i_iss_reg,
    input  logic [NRP-1:0]      i_rd_en,
    input  logic [NRP*RAW-1:0]  i_rd_reg,
    output logic [NRP*DW-1:0]   o_rd_data,
    output logic [NRP-1:0]      o_rd_busy,
    output logic [(2**RAW)-1:0] o_busy_vec,
    output logic                o_any_busy
);

    localparam int DP = 2**RAW;

    logic [DW-1:0] regs [DP];
    logic [DP-1:0] busy_q;

    logic wr_ok;
    logic iss_ok;

    assign wr_ok  = i_wr_en && (i_wr_reg != '0);
    assign iss_ok = i_iss_en && (i_iss_reg != '0);

    // Issue is applied after write so that a same-register collision leaves the entry busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DP; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs[i_wr_reg]   <= i_wr_data;
                busy_q[i_wr_reg] <= 1'b0;
            end
            if (iss_ok) begin
                busy_q[i_iss_reg] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [RAW-1:0] addr;
        logic           fwd;
        logic [DW-1:0]  data;
        logic           bsy;

        assign addr = i_rd_reg[p*RAW +: RAW];
        assign fwd  = (BYPASS == 1) && i_wr_en && (i_wr_reg == addr);

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (i_rd_en[p] && (addr != '0)) begin
                if (fwd) begin
                    data = i_wr_data;
                end else begin
                    data = regs[addr];
                    bsy  = busy_q[addr];
                end
            end
        end

        assign o_rd_data[p*DW +: DW] = data;
        assign o_rd_busy[p]          = bsy;
    end

    // Entry 0 is never written, so the vector carries a constant zero in bit 0.
    assign o_busy_vec = busy_q;
    assign o_any_busy = |busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb with bypassing and non-bypassing instances
// Stimulus pushes expected per-port results; a negedge monitor pops and compares against both instances.
module tb_reg_file_sb;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [4:0]   wr_reg;
    logic [31:0]  wr_data;
    logic         iss_en;
    logic [4:0]   iss_reg;
    logic [3:0]   rd_en;
    logic [19:0]  rd_reg;

    logic [127:0] rd_data_b, rd_data_n;
    logic [3:0]   rd_busy_b, rd_busy_n;
    logic [31:0]  bvec_b, bvec_n;
    logic         any_b, any_n;

    always #5 clk = ~clk;

    reg_file_sb #(.RAW(5), .DW(32), .NRP(4), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_reg(wr_reg), .i_wr_data(wr_data),
        .i_iss_en(iss_en), .i_iss_reg(iss_reg),
        .i_rd_en(rd_en), .i_rd_reg(rd_reg),
        .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
        .o_busy_vec(bvec_b), .o_any_busy(any_b)
    );

    reg_file_sb #(.RAW(5), .DW(32), .NRP(4), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_reg(wr_reg), .i_wr_data(wr_data),
        .i_iss_en(iss_en), .i_iss_reg(iss_reg),
        .i_rd_en(rd_en), .i_rd_reg(rd_reg),
        .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
        .o_busy_vec(bvec_n), .o_any_busy(any_n)
    );

    typedef struct {
        int          step;
        bit          dut;
        int          port;
        logic [31:0] data;
        logic        busy;
        logic [31:0] bvec;
        logic        any;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    task automatic chk(input string nm, input int st, input int d, input int p,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d dut=%0d port=%0d got=%h want=%h", nm, st, d, p, act, req);
        end
    endtask

    // dut 0 = bypassing instance, dut 1 = non-bypassing instance
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.dut == 1'b0) begin
                chk("rd_data", e.step, 0, e.port, rd_data_b[e.port*32 +: 32], e.data);
                chk("rd_busy", e.step, 0, e.port, {31'd0, rd_busy_b[e.port]}, {31'd0, e.busy});
                chk("busy_vec", e.step, 0, e.port, bvec_b, e.bvec);
                chk("any_busy", e.step, 0, e.port, {31'd0, any_b}, {31'd0, e.any});
            end else begin
                chk("rd_data", e.step, 1, e.port, rd_data_n[e.port*32 +: 32], e.data);
                chk("rd_busy", e.step, 1, e.port, {31'd0, rd_busy_n[e.port]}, {31'd0, e.busy});
                chk("busy_vec", e.step, 1, e.port, bvec_n, e.bvec);
                chk("any_busy", e.step, 1, e.port, {31'd0, any_n}, {31'd0, e.any});
            end
        end
    end

    task automatic ex(input bit d, input int p, input logic [31:0] data, input logic busy,
                      input logic [31:0] bvec, input logic any);
        exp_t e;
        e.step = step; e.dut = d; e.port = p;
        e.data = data; e.busy = busy; e.bvec = bvec; e.any = any;
        sb.push_back(e);
    endtask

    // Same expectation for both instances.
    task automatic ex2(input int p, input logic [31:0] data, input logic busy,
                       input logic [31:0] bvec, input logic any);
        ex(1'b0, p, data, busy, bvec, any);
        ex(1'b1, p, data, busy, bvec, any);
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; wr_reg = '0; wr_data = '0;
        iss_en = 1'b0; iss_reg = '0; rd_en = '0; rd_reg = '0;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [4:0] r);
        rd_en[p] = en;
        rd_reg[p*5 +: 5] = r;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        wr_en = 1'b1; wr_reg = r; wr_data = d;
    endtask

    task automatic iss(input logic [4:0] r);
        iss_en = 1'b1; iss_reg = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        step++;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        idle();

        // Reset state on all ports
        set_rd(0, 1, 5'd5); set_rd(1, 1, 5'd7); set_rd(2, 1, 5'd31); set_rd(3, 1, 5'd1);
        for (int p = 0; p < 4; p++) ex2(p, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // Reset clears a written value; reset beats a same-cycle write and issue
        wr(5'd5, 32'hDEADBEEF); set_rd(0, 1, 5'd5);
        ex(1'b0, 0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        ex(1'b1, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b1; wr(5'd8, 32'h55); iss(5'd6); set_rd(0, 1, 5'd5);
        ex2(0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        tick();
        set_rd(0, 1, 5'd5); set_rd(1, 1, 5'd8); set_rd(2, 1, 5'd6);
        ex2(0, 32'h0, 1'b0, 32'h0, 1'b0);
        ex2(1, 32'h0, 1'b0, 32'h0, 1'b0);
        ex2(2, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // Bypass versus next-cycle visibility
        wr(5'd7, 32'h12345678); set_rd(1, 1, 5'd7);
        ex(1'b0, 1, 32'h12345678, 1'b0, 32'h0, 1'b0);
        ex(1'b1, 1, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        set_rd(1, 1, 5'd7);
        ex2(1, 32'h12345678, 1'b0, 32'h0, 1'b0);
        tick();

        // x0 protection
        wr(5'd0, 32'hFFFFFFFF); iss(5'd0);
        for (int p = 0; p < 4; p++) begin set_rd(p, 1, 5'd0); ex2(p, 32'h0, 1'b0, 32'h0, 1'b0); end
        tick();
        for (int p = 0; p < 4; p++) begin set_rd(p, 1, 5'd0); ex2(p, 32'h0, 1'b0, 32'h0, 1'b0); end
        tick();

        // Scoreboard: issue x3 at t, write 0xA5 at t+4
        iss(5'd3); set_rd(0, 1, 5'd3);
        ex2(0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        set_rd(0, 1, 5'd3); set_rd(3, 1, 5'd3);
        ex2(0, 32'h0, 1'b1, 32'h8, 1'b1);
        ex2(3, 32'h0, 1'b1, 32'h8, 1'b1);
        tick();
        tick();
        tick();
        wr(5'd3, 32'hA5); set_rd(0, 1, 5'd3);
        ex(1'b0, 0, 32'hA5, 1'b0, 32'h8, 1'b1);
        ex(1'b1, 0, 32'h0, 1'b1, 32'h8, 1'b1);
        tick();
        set_rd(0, 1, 5'd3);
        ex2(0, 32'hA5, 1'b0, 32'h0, 1'b0);
        tick();

        // Issue and write the same register: issue wins, data stored
        iss(5'd9); wr(5'd9, 32'h99); set_rd(2, 1, 5'd9);
        ex(1'b0, 2, 32'h99, 1'b0, 32'h0, 1'b0);
        ex(1'b1, 2, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        set_rd(2, 1, 5'd9);
        ex2(2, 32'h99, 1'b1, 32'h200, 1'b1);
        tick();
        // Issue x4 while writing x9
        iss(5'd4); wr(5'd9, 32'h77); set_rd(2, 1, 5'd9); set_rd(3, 1, 5'd4);
        ex(1'b0, 2, 32'h77, 1'b0, 32'h200, 1'b1);
        ex(1'b1, 2, 32'h99, 1'b1, 32'h200, 1'b1);
        ex2(3, 32'h0, 1'b0, 32'h200, 1'b1);
        tick();
        set_rd(2, 1, 5'd9); set_rd(3, 1, 5'd4);
        ex2(2, 32'h77, 1'b0, 32'h10, 1'b1);
        ex2(3, 32'h0, 1'b1, 32'h10, 1'b1);
        tick();
        // Re-issue of a busy register, then a single write clears it
        iss(5'd4);
        tick();
        set_rd(0, 1, 5'd4);
        ex2(0, 32'h0, 1'b1, 32'h10, 1'b1);
        tick();
        wr(5'd4, 32'h44);
        tick();
        set_rd(0, 1, 5'd4);
        ex2(0, 32'h44, 1'b0, 32'h0, 1'b0);
        tick();

        // All ports on x12 with mixed enables
        wr(5'd12, 32'h0BADF00D);
        tick();
        for (int p = 0; p < 4; p++) set_rd(p, (p % 2) == 1, 5'd12);
        ex2(0, 32'h0, 1'b0, 32'h0, 1'b0);
        ex2(1, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
        ex2(2, 32'h0, 1'b0, 32'h0, 1'b0);
        ex2(3, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
        tick();

        tick();
        tick();
        chk("sb_drain", step, 0, 0, sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
